// File: rtl/npu_tile_scheduler_pkg.sv
// Shared definitions for the NPU tile scheduler: FSM states, register map,
// CTRL/STATUS bit positions and the scheduler window base in the memory map.
package npu_tile_scheduler_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SETUP    = 3'd1,
        ST_ISSUE    = 3'd2,
        ST_WAIT_OS  = 3'd3,
        ST_ISSUE_MV = 3'd4,
        ST_WAIT_MV  = 3'd5,
        ST_ADVANCE  = 3'd6,
        ST_DONE     = 3'd7
    } sched_state_e;

    // Word index (byte offset bits [5:2]) of each register.
    localparam logic [3:0] REG_CTRL     = 4'h0;
    localparam logic [3:0] REG_STATUS   = 4'h1;
    localparam logic [3:0] REG_A_BASE   = 4'h2;
    localparam logic [3:0] REG_ROWS     = 4'h3;
    localparam logic [3:0] REG_W_BASE   = 4'h4;
    localparam logic [3:0] REG_COLS     = 4'h5;
    localparam logic [3:0] REG_O_BASE   = 4'h6;
    localparam logic [3:0] REG_A_STRIDE = 4'h7;
    localparam logic [3:0] REG_W_STRIDE = 4'h8;
    localparam logic [3:0] REG_O_STRIDE = 4'h9;
    localparam logic [3:0] REG_TILE_CNT = 4'hA;

    localparam int CTRL_START_BIT = 0;
    localparam int CTRL_ABORT_BIT = 1;
    localparam int CTRL_MV_EN_BIT = 2;

    localparam int STATUS_DONE_BIT    = 0;
    localparam int STATUS_BUSY_BIT    = 1;
    localparam int STATUS_ERR_BIT     = 2;
    localparam int STATUS_ABORTED_BIT = 3;

    localparam logic [31:0] NPU_SCHED_START = 32'h4000_2000;

    function automatic logic sched_busy(input sched_state_e s);
        return !((s == ST_IDLE) || (s == ST_DONE));
    endfunction

endpackage

// File: rtl/npu_tile_scheduler_iter.sv
// Tile walker: row-tile outer / col-tile inner, remainder sizing of the edge
// tiles and incremental base pointers (adders only, no multipliers).
module npu_tile_scheduler_iter
    import npu_tile_scheduler_pkg::*;
#(
    parameter int DWidth     = 32,
    parameter int ARRAY_DIM  = 16,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_load,
    input  logic                  i_step,
    input  logic [ADDR_WIDTH-1:0] i_a_base,
    input  logic [ADDR_WIDTH-1:0] i_w_base,
    input  logic [ADDR_WIDTH-1:0] i_o_base,
    input  logic [ADDR_WIDTH-1:0] i_a_stride,
    input  logic [ADDR_WIDTH-1:0] i_w_stride,
    input  logic [ADDR_WIDTH-1:0] i_o_stride,
    input  logic [DWidth-1:0]     i_rows,
    input  logic [DWidth-1:0]     i_cols,
    output logic [ADDR_WIDTH-1:0] o_a_ptr,
    output logic [ADDR_WIDTH-1:0] o_w_ptr,
    output logic [ADDR_WIDTH-1:0] o_o_ptr,
    output logic [DWidth-1:0]     o_a_rows,
    output logic [DWidth-1:0]     o_w_cols,
    output logic                  o_last
);

    localparam logic [DWidth-1:0] DIM = DWidth'(ARRAY_DIM);

    logic [DWidth-1:0]     r_rows_rem;
    logic [DWidth-1:0]     r_cols_rem;
    logic [ADDR_WIDTH-1:0] r_a_ptr;
    logic [ADDR_WIDTH-1:0] r_w_ptr;
    logic [ADDR_WIDTH-1:0] r_o_ptr;
    logic                  w_row_last;
    logic                  w_col_last;

    // Remaining rows/cols include the current tile, so the edge tile is simply
    // whatever remains once it drops to ARRAY_DIM or below.
    assign w_row_last = (r_rows_rem <= DIM);
    assign w_col_last = (r_cols_rem <= DIM);

    assign o_a_rows = w_row_last ? r_rows_rem : DIM;
    assign o_w_cols = w_col_last ? r_cols_rem : DIM;
    assign o_a_ptr  = r_a_ptr;
    assign o_w_ptr  = r_w_ptr;
    assign o_o_ptr  = r_o_ptr;
    assign o_last   = w_row_last && w_col_last;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rows_rem <= '0;
            r_cols_rem <= '0;
            r_a_ptr    <= '0;
            r_w_ptr    <= '0;
            r_o_ptr    <= '0;
        end else if (i_load) begin
            r_rows_rem <= i_rows;
            r_cols_rem <= i_cols;
            r_a_ptr    <= i_a_base;
            r_w_ptr    <= i_w_base;
            r_o_ptr    <= i_o_base;
        end else if (i_step) begin
            r_o_ptr <= r_o_ptr + i_o_stride;
            if (w_col_last) begin
                r_cols_rem <= i_cols;
                r_w_ptr    <= i_w_base;
                r_rows_rem <= r_rows_rem - DIM;
                r_a_ptr    <= r_a_ptr + i_a_stride;
            end else begin
                r_cols_rem <= r_cols_rem - DIM;
                r_w_ptr    <= r_w_ptr + i_w_stride;
            end
        end
    end

endmodule

// File: rtl/npu_tile_scheduler.sv
// Memory-mapped GEMM tile sequencer: holds the config registers, walks the
// tile grid and drives start/done pulse handshakes to the OS core and mover.
module npu_tile_scheduler
    import npu_tile_scheduler_pkg::*;
#(
    parameter int DWidth     = 32,
    parameter int ARRAY_DIM  = 16,
    parameter int ADDR_WIDTH = 32,
    parameter int TIMEOUT    = 4096
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  cen_i,
    input  logic                  wen_i,
    input  logic [DWidth-1:0]     addr_i,
    input  logic [DWidth-1:0]     wdata_i,
    output logic [DWidth-1:0]     rdata_o,
    output logic [ADDR_WIDTH-1:0] a_base_o,
    output logic [DWidth-1:0]     a_rows_o,
    output logic [ADDR_WIDTH-1:0] w_base_o,
    output logic [DWidth-1:0]     w_cols_o,
    output logic [ADDR_WIDTH-1:0] o_base_o,
    output logic                  os_start_o,
    input  logic                  os_done_i,
    output logic                  mv_start_o,
    input  logic                  mv_done_i,
    output logic                  busy_o,
    output sched_state_e          dbg_state_o
);

    localparam logic [31:0] TIMEOUT_L = 32'(TIMEOUT);

    // Handshake: *_start_o is a one-cycle pulse issuing one job; the engine
    // answers with a one-cycle *_done_i pulse, which only counts while the FSM
    // sits in the matching WAIT state. One job is outstanding at a time.

    sched_state_e          r_state;
    logic [ADDR_WIDTH-1:0] r_a_base;
    logic [ADDR_WIDTH-1:0] r_w_base;
    logic [ADDR_WIDTH-1:0] r_o_base;
    logic [ADDR_WIDTH-1:0] r_a_stride;
    logic [ADDR_WIDTH-1:0] r_w_stride;
    logic [ADDR_WIDTH-1:0] r_o_stride;
    logic [DWidth-1:0]     r_rows;
    logic [DWidth-1:0]     r_cols;
    logic [DWidth-1:0]     r_tile_cnt;
    logic [31:0]           r_wait_cnt;
    logic                  r_os_start;
    logic                  r_mv_start;
    logic                  r_mv_en;
    logic                  r_done;
    logic                  r_err;
    logic                  r_aborted;

    logic [3:0] w_idx;
    logic       w_wr;
    logic       w_rd;
    logic       w_busy;
    logic       w_ctrl_wr;
    logic       w_abort;
    logic       w_start;
    logic       w_dims_ok;
    logic       w_load;
    logic       w_step;
    logic       w_last;
    logic       w_unused;

    assign w_idx     = addr_i[5:2];
    assign w_wr      = cen_i && wen_i;
    assign w_rd      = cen_i && !wen_i;
    assign w_busy    = sched_busy(r_state);
    assign w_ctrl_wr = w_wr && (w_idx == REG_CTRL);
    assign w_abort   = w_ctrl_wr && wdata_i[CTRL_ABORT_BIT];
    assign w_start   = w_ctrl_wr && wdata_i[CTRL_START_BIT] && !w_abort && !w_busy;
    assign w_dims_ok = (r_rows != '0) && (r_cols != '0);
    assign w_load    = w_start && w_dims_ok;
    assign w_step    = (r_state == ST_ADVANCE) && !w_last;
    assign w_unused  = ^{addr_i[DWidth-1:6], addr_i[1:0]};

    assign os_start_o  = r_os_start;
    assign mv_start_o  = r_mv_start;
    assign busy_o      = w_busy;
    assign dbg_state_o = r_state;

    npu_tile_scheduler_iter #(
        .DWidth    (DWidth),
        .ARRAY_DIM (ARRAY_DIM),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_iter (
        .i_clk     (clk_i),
        .i_rst_n   (rst_ni),
        .i_load    (w_load),
        .i_step    (w_step),
        .i_a_base  (r_a_base),
        .i_w_base  (r_w_base),
        .i_o_base  (r_o_base),
        .i_a_stride(r_a_stride),
        .i_w_stride(r_w_stride),
        .i_o_stride(r_o_stride),
        .i_rows    (r_rows),
        .i_cols    (r_cols),
        .o_a_ptr   (a_base_o),
        .o_w_ptr   (w_base_o),
        .o_o_ptr   (o_base_o),
        .o_a_rows  (a_rows_o),
        .o_w_cols  (w_cols_o),
        .o_last    (w_last)
    );

    // Config is frozen while a job runs so the walker never sees it change.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_a_base   <= '0;
            r_w_base   <= '0;
            r_o_base   <= '0;
            r_a_stride <= '0;
            r_w_stride <= '0;
            r_o_stride <= '0;
            r_rows     <= '0;
            r_cols     <= '0;
        end else if (w_wr && !w_busy) begin
            case (w_idx)
                REG_A_BASE:   r_a_base   <= ADDR_WIDTH'(wdata_i);
                REG_ROWS:     r_rows     <= wdata_i;
                REG_W_BASE:   r_w_base   <= ADDR_WIDTH'(wdata_i);
                REG_COLS:     r_cols     <= wdata_i;
                REG_O_BASE:   r_o_base   <= ADDR_WIDTH'(wdata_i);
                REG_A_STRIDE: r_a_stride <= ADDR_WIDTH'(wdata_i);
                REG_W_STRIDE: r_w_stride <= ADDR_WIDTH'(wdata_i);
                REG_O_STRIDE: r_o_stride <= ADDR_WIDTH'(wdata_i);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdata_o <= '0;
        end else if (w_rd) begin
            case (w_idx)
                REG_STATUS:   rdata_o <= DWidth'({r_aborted, r_err, w_busy, r_done});
                REG_A_BASE:   rdata_o <= DWidth'(r_a_base);
                REG_ROWS:     rdata_o <= r_rows;
                REG_W_BASE:   rdata_o <= DWidth'(r_w_base);
                REG_COLS:     rdata_o <= r_cols;
                REG_O_BASE:   rdata_o <= DWidth'(r_o_base);
                REG_A_STRIDE: rdata_o <= DWidth'(r_a_stride);
                REG_W_STRIDE: rdata_o <= DWidth'(r_w_stride);
                REG_O_STRIDE: rdata_o <= DWidth'(r_o_stride);
                REG_TILE_CNT: rdata_o <= r_tile_cnt;
                default:      rdata_o <= '0;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= ST_IDLE;
            r_os_start <= 1'b0;
            r_mv_start <= 1'b0;
            r_mv_en    <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_aborted  <= 1'b0;
            r_tile_cnt <= '0;
            r_wait_cnt <= '0;
        end else begin
            r_os_start <= 1'b0;
            r_mv_start <= 1'b0;
            if (w_abort) begin
                r_state   <= ST_IDLE;
                r_aborted <= 1'b1;
                r_done    <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE, ST_DONE: begin
                        if (w_start) begin
                            r_aborted  <= 1'b0;
                            r_tile_cnt <= '0;
                            r_mv_en    <= wdata_i[CTRL_MV_EN_BIT];
                            // An empty GEMM finishes immediately as an error.
                            if (w_dims_ok) begin
                                r_done  <= 1'b0;
                                r_err   <= 1'b0;
                                r_state <= ST_SETUP;
                            end else begin
                                r_done  <= 1'b1;
                                r_err   <= 1'b1;
                                r_state <= ST_DONE;
                            end
                        end
                    end
                    ST_SETUP: begin
                        r_os_start <= 1'b1;
                        r_state    <= ST_ISSUE;
                    end
                    ST_ISSUE: begin
                        r_wait_cnt <= '0;
                        r_state    <= ST_WAIT_OS;
                    end
                    ST_WAIT_OS: begin
                        if (os_done_i) begin
                            if (r_mv_en) begin
                                r_mv_start <= 1'b1;
                                r_state    <= ST_ISSUE_MV;
                            end else begin
                                r_state <= ST_ADVANCE;
                            end
                        end else if (r_wait_cnt > TIMEOUT_L) begin
                            r_err   <= 1'b1;
                            r_done  <= 1'b1;
                            r_state <= ST_DONE;
                        end else begin
                            r_wait_cnt <= r_wait_cnt + 32'd1;
                        end
                    end
                    ST_ISSUE_MV: begin
                        r_wait_cnt <= '0;
                        r_state    <= ST_WAIT_MV;
                    end
                    ST_WAIT_MV: begin
                        if (mv_done_i) begin
                            r_state <= ST_ADVANCE;
                        end else if (r_wait_cnt > TIMEOUT_L) begin
                            r_err   <= 1'b1;
                            r_done  <= 1'b1;
                            r_state <= ST_DONE;
                        end else begin
                            r_wait_cnt <= r_wait_cnt + 32'd1;
                        end
                    end
                    ST_ADVANCE: begin
                        r_tile_cnt <= r_tile_cnt + 1'b1;
                        if (w_last) begin
                            r_done  <= 1'b1;
                            r_state <= ST_DONE;
                        end else begin
                            r_state <= ST_SETUP;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_npu_tile_scheduler.sv
// Directed bench for npu_tile_scheduler: register programming, tile walk order,
// move chaining, abort, error/timeout paths and reset behaviour.
module tb_npu_tile_scheduler;
    import npu_tile_scheduler_pkg::*;

    localparam int DW  = 32;
    localparam int AW  = 32;
    localparam int TMO = 32;
    localparam int TW  = 160;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cen = 1'b0;
    logic          wen = 1'b0;
    logic [DW-1:0] addr = '0;
    logic [DW-1:0] wdata = '0;
    logic [DW-1:0] rdata;
    logic [AW-1:0] a_base;
    logic [AW-1:0] w_base;
    logic [AW-1:0] o_base;
    logic [DW-1:0] a_rows;
    logic [DW-1:0] w_cols;
    logic          os_start;
    logic          mv_start;
    logic          busy;
    logic          os_done;
    logic          mv_done;
    logic          os_done_r = 1'b0;
    logic          mv_done_r = 1'b0;
    logic          man_os_done = 1'b0;
    logic          resp_en = 1'b1;
    sched_state_e  dbg_state;

    int n_checks = 0;
    int n_errors = 0;
    int os_pulses = 0;
    int mv_pulses = 0;
    int viol = 0;
    int os_dly = 0;
    int mv_dly = 0;
    logic os_out = 1'b0;
    logic mv_out = 1'b0;

    logic [TW-1:0] exp_q[$];
    logic [TW-1:0] obs_mem [0:63];

    assign os_done = os_done_r | man_os_done;
    assign mv_done = mv_done_r;

    npu_tile_scheduler #(
        .DWidth(DW), .ARRAY_DIM(16), .ADDR_WIDTH(AW), .TIMEOUT(TMO)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .cen_i      (cen),
        .wen_i      (wen),
        .addr_i     (addr),
        .wdata_i    (wdata),
        .rdata_o    (rdata),
        .a_base_o   (a_base),
        .a_rows_o   (a_rows),
        .w_base_o   (w_base),
        .w_cols_o   (w_cols),
        .o_base_o   (o_base),
        .os_start_o (os_start),
        .os_done_i  (os_done),
        .mv_start_o (mv_start),
        .mv_done_i  (mv_done),
        .busy_o     (busy),
        .dbg_state_o(dbg_state)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- engine responders ----------------
    always @(negedge clk) begin
        os_done_r = 1'b0;
        mv_done_r = 1'b0;
        if (os_dly > 0) begin
            os_dly--;
            if (os_dly == 0) os_done_r = resp_en;
        end
        if (mv_dly > 0) begin
            mv_dly--;
            if (mv_dly == 0) mv_done_r = resp_en;
        end
        if (os_start && resp_en) os_dly = 3;
        if (mv_start && resp_en) mv_dly = 2;
    end

    // ---------------- pulse monitor ----------------
    always @(posedge clk) begin
        #1;
        if (!busy) begin
            os_out = 1'b0;
            mv_out = 1'b0;
        end
        if (os_done) os_out = 1'b0;
        if (mv_done) mv_out = 1'b0;
        if (os_start) begin
            if (os_out || mv_out || mv_start) viol++;
            os_out = 1'b1;
            obs_mem[os_pulses % 64] = {a_base, a_rows, w_base, w_cols, o_base};
            os_pulses++;
        end
        if (mv_start) begin
            if (os_out || mv_out) viol++;
            mv_out = 1'b1;
            mv_pulses++;
        end
    end

    // ---------------- checker / drivers ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic reg_write(input logic [5:0] a, input logic [31:0] d);
        @(negedge clk);
        cen = 1'b1; wen = 1'b1; addr = 32'(a); wdata = d;
        @(negedge clk);
        cen = 1'b0; wen = 1'b0;
    endtask

    task automatic reg_read(input logic [5:0] a, output logic [31:0] d);
        @(negedge clk);
        cen = 1'b1; wen = 1'b0; addr = 32'(a);
        @(negedge clk);
        cen = 1'b0;
        d = rdata;
    endtask

    task automatic read_check(input string tag, input logic [5:0] a, input logic [31:0] exp);
        logic [31:0] d;
        reg_read(a, d);
        check(tag, d, exp);
    endtask

    task automatic cfg(input logic [31:0] ab, input logic [31:0] rows, input logic [31:0] wb,
                       input logic [31:0] cols, input logic [31:0] ob, input logic [31:0] as,
                       input logic [31:0] ws, input logic [31:0] ostr);
        reg_write(6'h08, ab);
        reg_write(6'h0C, rows);
        reg_write(6'h10, wb);
        reg_write(6'h14, cols);
        reg_write(6'h18, ob);
        reg_write(6'h1C, as);
        reg_write(6'h20, ws);
        reg_write(6'h24, ostr);
    endtask

    task automatic push_tile(input logic [31:0] ab, input logic [31:0] ar, input logic [31:0] wb,
                             input logic [31:0] wc, input logic [31:0] ob);
        exp_q.push_back({ab, ar, wb, wc, ob});
    endtask

    task automatic wait_idle(input string tag, input int max);
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (!busy) break;
        end
        check(tag, busy, 1'b0);
    endtask

    task automatic wait_os_start(input string tag, input int max);
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (os_start) break;
        end
        check(tag, os_start, 1'b1);
    endtask

    task automatic compare_tiles(input string name, input int base);
        int n;
        logic [TW-1:0] e;
        logic [TW-1:0] o;
        n = exp_q.size();
        check({name, " os_start count"}, os_pulses - base, n);
        for (int k = 0; k < n; k++) begin
            e = exp_q.pop_front();
            o = obs_mem[(base + k) % 64];
            check($sformatf("%s t%0d a_base", name, k), o[159:128], e[159:128]);
            check($sformatf("%s t%0d a_rows", name, k), o[127:96], e[127:96]);
            check($sformatf("%s t%0d w_base", name, k), o[95:64], e[95:64]);
            check($sformatf("%s t%0d w_cols", name, k), o[63:32], e[63:32]);
            check($sformatf("%s t%0d o_base", name, k), o[31:0], e[31:0]);
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int os_base;
        int mv_base;

        repeat (3) @(negedge clk);
        check("reset os_start", os_start, 1'b0);
        check("reset busy", busy, 1'b0);
        check("reset a_rows", a_rows, 32'd0);
        check("reset state", dbg_state, ST_IDLE);
        rst_n = 1'b1;
        read_check("reset STATUS", 6'h04, 32'h0);
        read_check("reset TILE_CNT", 6'h28, 32'h0);
        read_check("unmapped read", 6'h3C, 32'h0);

        // 12x12: single partial tile, exact start latency
        cfg(32'h1000, 32'd12, 32'h2000, 32'd12, 32'h3000, 32'd0, 32'd0, 32'd0);
        read_check("ROWS readback", 6'h0C, 32'd12);
        push_tile(32'h1000, 32'd12, 32'h2000, 32'd12, 32'h3000);
        os_base = os_pulses; mv_base = mv_pulses;
        reg_write(6'h00, 32'h1);
        check("t1 state after start", dbg_state, ST_SETUP);
        check("t1 no early os_start", os_start, 1'b0);
        check("t1 a_rows in SETUP", a_rows, 32'd12);
        @(negedge clk);
        check("t1 os_start latency", os_start, 1'b1);
        @(negedge clk);
        check("t1 os_start one cycle", os_start, 1'b0);
        wait_idle("t1 finish", 200);
        read_check("t1 STATUS", 6'h04, 32'h1);
        read_check("t1 TILE_CNT", 6'h28, 32'd1);
        compare_tiles("t1", os_base);
        check("t1 mv pulses", mv_pulses - mv_base, 0);

        // 40x20 walk: 3 row-tiles x 2 col-tiles
        cfg(32'h0, 32'd40, 32'h0, 32'd20, 32'h0, 32'd64, 32'd16, 32'd256);
        push_tile(32'd0,   32'd16, 32'd0,  32'd16, 32'd0);
        push_tile(32'd0,   32'd16, 32'd16, 32'd4,  32'd256);
        push_tile(32'd64,  32'd16, 32'd0,  32'd16, 32'd512);
        push_tile(32'd64,  32'd16, 32'd16, 32'd4,  32'd768);
        push_tile(32'd128, 32'd8,  32'd0,  32'd16, 32'd1024);
        push_tile(32'd128, 32'd8,  32'd16, 32'd4,  32'd1280);
        os_base = os_pulses; mv_base = mv_pulses;
        reg_write(6'h00, 32'h1);
        wait_idle("t2 finish", 400);
        read_check("t2 STATUS", 6'h04, 32'h1);
        read_check("t2 TILE_CNT", 6'h28, 32'd6);
        compare_tiles("t2", os_base);
        check("t2 mv pulses", mv_pulses - mv_base, 0);

        // abort and start in the same write: abort wins
        os_base = os_pulses;
        reg_write(6'h00, 32'h3);
        check("abort+start state", dbg_state, ST_IDLE);
        repeat (4) @(negedge clk);
        check("abort+start no pulse", os_pulses - os_base, 0);
        read_check("abort+start STATUS", 6'h04, 32'h8);

        // move chaining, 2x1 tiles
        cfg(32'h100, 32'd32, 32'h200, 32'd8, 32'h300, 32'h40, 32'h10, 32'h80);
        push_tile(32'h100, 32'd16, 32'h200, 32'd8, 32'h300);
        push_tile(32'h140, 32'd16, 32'h200, 32'd8, 32'h380);
        os_base = os_pulses; mv_base = mv_pulses;
        reg_write(6'h00, 32'h5);
        wait_idle("t3 finish", 400);
        read_check("t3 STATUS", 6'h04, 32'h1);
        read_check("t3 TILE_CNT", 6'h28, 32'd2);
        compare_tiles("t3", os_base);
        check("t3 mv pulses", mv_pulses - mv_base, 2);
        check("t3 pulse overlap", viol, 0);

        // abort during WAIT_OS of tile 2
        resp_en = 1'b0;
        cfg(32'h0, 32'd40, 32'h0, 32'd20, 32'h0, 32'd64, 32'd16, 32'd256);
        push_tile(32'd0, 32'd16, 32'd0,  32'd16, 32'd0);
        push_tile(32'd0, 32'd16, 32'd16, 32'd4,  32'd256);
        os_base = os_pulses;
        reg_write(6'h00, 32'h1);
        wait_os_start("t4 tile1 start", 20);
        repeat (2) @(negedge clk);
        man_os_done = 1'b1;
        @(negedge clk);
        man_os_done = 1'b0;
        wait_os_start("t4 tile2 start", 20);
        repeat (2) @(negedge clk);
        check("t4 in WAIT_OS", dbg_state, ST_WAIT_OS);
        reg_write(6'h00, 32'h2);
        check("t4 state after abort", dbg_state, ST_IDLE);
        check("t4 busy after abort", busy, 1'b0);
        man_os_done = 1'b1;
        @(negedge clk);
        man_os_done = 1'b0;
        repeat (4) @(negedge clk);
        check("t4 late done ignored", dbg_state, ST_IDLE);
        compare_tiles("t4", os_base);
        read_check("t4 STATUS", 6'h04, 32'h8);
        read_check("t4 TILE_CNT", 6'h28, 32'd1);

        // ROWS==0: error, no pulses
        cfg(32'h0, 32'd0, 32'h0, 32'd16, 32'h0, 32'd0, 32'd0, 32'd0);
        os_base = os_pulses;
        reg_write(6'h00, 32'h1);
        repeat (4) @(negedge clk);
        check("t5 zero rows pulses", os_pulses - os_base, 0);
        check("t5 zero rows state", dbg_state, ST_DONE);
        read_check("t5 zero rows STATUS", 6'h04, 32'h5);

        // os_done never returned: timeout
        cfg(32'h0, 32'd16, 32'h0, 32'd16, 32'h0, 32'd0, 32'd0, 32'd0);
        push_tile(32'd0, 32'd16, 32'd0, 32'd16, 32'd0);
        os_base = os_pulses;
        reg_write(6'h00, 32'h1);
        wait_idle("t6 timeout finish", 200);
        read_check("t6 timeout STATUS", 6'h04, 32'h5);
        read_check("t6 timeout TILE_CNT", 6'h28, 32'd0);
        compare_tiles("t6", os_base);

        // config/start writes while busy, then reset mid-run
        push_tile(32'd0, 32'd16, 32'd0, 32'd16, 32'd0);
        os_base = os_pulses;
        reg_write(6'h00, 32'h1);
        wait_os_start("t7 start", 20);
        reg_write(6'h0C, 32'd99);
        read_check("t7 ROWS held while busy", 6'h0C, 32'd16);
        reg_write(6'h00, 32'h1);
        check("t7 start while busy ignored", dbg_state, ST_WAIT_OS);
        check("t7 busy", busy, 1'b1);
        compare_tiles("t7", os_base);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("t7 reset state", dbg_state, ST_IDLE);
        check("t7 reset busy", busy, 1'b0);
        check("t7 reset a_base", a_base, 32'd0);
        check("t7 reset a_rows", a_rows, 32'd0);
        check("t7 reset w_cols", w_cols, 32'd0);
        check("t7 reset o_base", o_base, 32'd0);
        check("t7 reset os_start", os_start, 1'b0);
        check("t7 reset mv_start", mv_start, 1'b0);
        check("t7 reset rdata", rdata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        read_check("t7 ROWS after reset", 6'h0C, 32'd0);
        check("final pulse overlap", viol, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
